overlap_add: RTL and testbench

OVERLAP_ADD -- requirements
Module: overlap_add

---
 rtl/overlap_add_pkg.sv | 19 +
 rtl/ola_tail_buf.sv | 34 +++
 rtl/overlap_add.sv | 158 +++++++++++++++
 tb/tb_overlap_add.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlap_add_pkg.sv
// Shared defaults, state encoding and small helpers for the overlap-add reconstructor.
package overlap_add_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAME = 128;
  localparam int DEF_HOP   = DEF_FRAME / 2;

  typedef enum logic [1:0] {
    HEAD  = 2'd0,
    TAIL  = 2'd1,
    FLUSH = 2'd2
  } ola_state_e;

  // Address width that stays legal for a depth of one.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ola_tail_buf.sv
// HOP-entry storage for the second half of the previous frame; entries clear as they are read out.
module ola_tail_buf
  import overlap_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOP   = DEF_HOP,
  parameter int AW    = addr_bits(HOP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_clr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [HOP];

  assign rd_data = mem[rd_addr];

  // NOTE: this array is reset on purpose (a stale tail after reset would corrupt
  // the first frame), so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HOP; i++) mem[i] <= '0;
    end else begin
      if (rd_clr) mem[rd_addr] <= '0;
      if (wr_en)  mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/overlap_add.sv
// Overlap-add of half-overlapping windowed frames: first half sums with the stored tail,
// second half refills the tail; flush drains the tail.
module overlap_add
  import overlap_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAME = DEF_FRAME,
  parameter int HOP   = FRAME / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             frame_err
);

  localparam int IW = addr_bits(FRAME);
  localparam int AW = addr_bits(HOP);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME - 1);
  localparam logic [IW-1:0] IDX_HOPM = IW'(HOP - 1);
  localparam logic [AW-1:0] FA_LAST  = AW'(HOP - 1);

  ola_state_e       state_q;
  logic [IW-1:0]    idx_q;
  logic [AW-1:0]    faddr_q;
  logic             running_q;
  logic             m_valid_q;
  logic [WIDTH-1:0] m_data_q;
  logic             frame_err_q;

  logic             out_free;
  logic             flush_go;
  logic             accept;
  logic             at_last;
  logic             framing_bad;
  logic [WIDTH:0]   head_sum;
  logic [WIDTH-1:0] head_sat;
  logic             buf_wr_en;
  logic [AW-1:0]    buf_wr_addr;
  logic [AW-1:0]    buf_rd_addr;
  logic             buf_rd_clr;
  logic [WIDTH-1:0] buf_rd_data;

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign frame_err = frame_err_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    s_ready     = 1'b0;
    out_free    = !m_valid_q || m_ready;
    flush_go    = running_q && flush && (state_q == HEAD) && (idx_q == '0);
    at_last     = (idx_q == IDX_LAST);
    framing_bad = (s_last != at_last);
    unique case (state_q)
      HEAD:    s_ready = running_q && out_free && !flush_go;
      TAIL:    s_ready = running_q;
      default: s_ready = 1'b0;
    endcase
    accept      = s_valid && s_ready;
    head_sum    = {1'b0, s_data} + {1'b0, buf_rd_data};
    head_sat    = head_sum[WIDTH] ? {WIDTH{1'b1}} : head_sum[WIDTH-1:0];
    // A mis-framed sample never lands in the tail, so the stored tail survives the error.
    buf_wr_en   = accept && (state_q == TAIL) && !framing_bad;
    buf_wr_addr = AW'(idx_q - IW'(HOP));
    buf_rd_addr = (state_q == FLUSH) ? faddr_q : idx_q[AW-1:0];
    buf_rd_clr  = (state_q == FLUSH) && out_free;
  end

  ola_tail_buf #(
    .WIDTH (WIDTH),
    .HOP   (HOP),
    .AW    (AW)
  ) u_tail (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_wr_addr),
    .wr_data (s_data),
    .rd_addr (buf_rd_addr),
    .rd_clr  (buf_rd_clr),
    .rd_data (buf_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HEAD;
      idx_q       <= '0;
      faddr_q     <= '0;
      running_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      running_q   <= 1'b1;
      frame_err_q <= 1'b0;
      if (m_ready) m_valid_q <= 1'b0;

      unique case (state_q)
        HEAD: begin
          if (flush_go) begin
            state_q <= FLUSH;
            faddr_q <= '0;
          end else if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= head_sat;
            if (framing_bad) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
              if (idx_q == IDX_HOPM) state_q <= TAIL;
            end
          end
        end

        TAIL: begin
          if (accept) begin
            if (framing_bad) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
              state_q     <= HEAD;
            end else if (at_last) begin
              idx_q   <= '0;
              state_q <= HEAD;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end

        FLUSH: begin
          if (out_free) begin
            m_valid_q <= 1'b1;
            m_data_q  <= buf_rd_data;
            faddr_q   <= faddr_q + AW'(1);
            if (faddr_q == FA_LAST) begin
              faddr_q <= '0;
              state_q <= HEAD;
            end
          end
        end

        default: state_q <= HEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_overlap_add.sv
// Scoreboard bench: driver pushes expected outputs from a frame-level model, monitor pops and compares.
module tb_overlap_add;

  localparam int WIDTH = 8;
  localparam int FRAME = 128;
  localparam int HOP   = 64;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [WIDTH-1:0] m_data;
  logic             frame_err;

  always #5 clk = ~clk;

  overlap_add #(.WIDTH(WIDTH), .FRAME(FRAME), .HOP(HOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_q[$];
  int m_tail[HOP];
  int m_idx    = 0;
  int exp_err  = 0;
  int seen_err = 0;
  int bp_mode  = 0;
  bit stall    = 1'b0;
  int held     = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: frame-level overlap-add rules.
  task automatic model_accept(input int x, input bit last);
    bit err;
    err = (last != (m_idx == FRAME - 1));
    if (m_idx < HOP) begin
      int s;
      s = x + m_tail[m_idx];
      exp_q.push_back((s > MAXV) ? MAXV : s);
    end else if (!err) begin
      m_tail[m_idx - HOP] = x;
    end
    if (err) begin
      exp_err++;
      m_idx = 0;
    end else begin
      m_idx = (m_idx + 1) % FRAME;
    end
  endtask

  task automatic model_flush();
    if (m_idx == 0) begin
      for (int i = 0; i < HOP; i++) begin
        exp_q.push_back(m_tail[i]);
        m_tail[i] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < HOP; i++) m_tail[i] = 0;
    m_idx = 0;
    exp_q.delete();
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x, input bit last, input bit with_flush);
    int  n;
    bit  ok;
    n       = 0;
    s_valid = 1'b1;
    s_data  = WIDTH'(x);
    s_last  = last;
    if (with_flush) begin
      flush = 1'b1;
      @(posedge clk);
      model_flush();
      #1 flush = 1'b0;
    end
    forever begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 4000) begin
        $display("FAIL send_timeout: got no s_ready expected s_ready within 4000 cycles");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
        $fatal(1, "stalled input");
      end
    end
    model_accept(x, last);
    #1 s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_frame_const(input int x);
    for (int i = 0; i < FRAME; i++) send(x, i == FRAME - 1, 1'b0);
  endtask

  task automatic send_frame_rand();
    for (int i = 0; i < FRAME; i++) send(int'($urandom_range(0, MAXV)), i == FRAME - 1, 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    model_flush();
    #1 flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output backpressure: 0 = always ready, 1 = random, 2 = toggling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = !m_ready;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: a transfer seen at the falling edge completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held);
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      if (m_valid && !m_ready && m_idx < HOP) check("s_ready_backpressure", s_ready, 0);
      if (frame_err) seen_err++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", m_data, -1);
        else check("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < HOP; i++) m_tail[i] = 0;

    #3;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("s_ready_before_first_edge", s_ready, 0);
    @(posedge clk);
    #1;

    // Two frames of 2 then flush: 64x2, 64x4, 64x2.
    repeat (2) send_frame_const(2);
    do_flush();
    drain();

    // Saturation: 64x200 then 64x255, flush gives 64x100.
    send_frame_const(200);
    send_frame_const(100);
    do_flush();
    drain();

    // Toggling output backpressure.
    bp_mode = 2;
    repeat (2) send_frame_const(2);
    do_flush();
    drain();
    bp_mode = 0;

    // Early s_last at idx 100: one-cycle frame_err, next sample restarts at idx 0.
    for (int i = 0; i < 100; i++) send(int'($urandom_range(0, MAXV)), 1'b0, 1'b0);
    send(int'($urandom_range(0, MAXV)), 1'b1, 1'b0);
    @(negedge clk);
    check("frame_err_pulse", frame_err, 1);
    @(negedge clk);
    check("frame_err_one_cycle", frame_err, 0);
    @(posedge clk);
    #1;
    send_frame_rand();
    do_flush();
    drain();

    // Flush at idx 10 ignored; flush with s_valid at idx 0 drains first.
    bp_mode = 1;
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, MAXV)), 1'b0, 1'b0);
    do_flush();
    for (int i = 10; i < FRAME; i++) send(int'($urandom_range(0, MAXV)), i == FRAME - 1, 1'b0);
    send(int'($urandom_range(0, MAXV)), 1'b0, 1'b1);
    for (int i = 1; i < FRAME; i++) send(int'($urandom_range(0, MAXV)), i == FRAME - 1, 1'b0);

    // Random data under random backpressure, including a missing s_last.
    repeat (2) send_frame_rand();
    for (int i = 0; i < FRAME; i++) send(int'($urandom_range(0, MAXV)), 1'b0, 1'b0);
    send_frame_rand();
    do_flush();
    drain();
    bp_mode = 0;

    // Reset at idx 80 clears the tail: one frame of 3 gives 64x3.
    for (int i = 0; i < 80; i++) send(int'($urandom_range(1, MAXV)), 1'b0, 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_valid", m_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame_const(3);
    do_flush();
    drain();

    check("frame_err_count", seen_err, exp_err);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
